// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode encoding, FSM state type and opcode helpers shared by
// the sequential ALU, its bus interface and the testbench.
// Optional feature macro used elsewhere in this slice: SEQ_ALU_FLAGS_EN.
package seq_alu_pkg;

    localparam int OPCODE_W = 5;

    typedef enum logic [OPCODE_W-1:0] {
        OP_AND  = 5'b00000,
        OP_OR   = 5'b00001,
        OP_NOT  = 5'b00010,
        OP_NEG  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_SUB  = 5'b00101,
        OP_MUL  = 5'b00110,
        OP_DIV  = 5'b00111,
        OP_SHR  = 5'b01000,
        OP_SHRA = 5'b01001,
        OP_SHL  = 5'b01010,
        OP_ROR  = 5'b01011,
        OP_ROL  = 5'b01100
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL and DIV are the only operations that run through the iterative core.
    function automatic logic is_iterative(input logic [OPCODE_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done request bus between the control unit (master) and
// the sequential ALU (slave). With SEQ_ALU_FLAGS_EN defined the bus also
// carries the registered Z/N/V condition flags.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [OPCODE_W-1:0]    opcode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   error;
`ifdef SEQ_ALU_FLAGS_EN
    logic                   flag_z;
    logic                   flag_n;
    logic                   flag_v;

    modport master (output start, opcode, a, b,
                    input  busy, done, result, error, flag_z, flag_n, flag_v);
    modport slave  (input  start, opcode, a, b,
                    output busy, done, result, error, flag_z, flag_n, flag_v);
`else
    modport master (output start, opcode, a, b,
                    input  busy, done, result, error);
    modport slave  (input  start, opcode, a, b,
                    output busy, done, result, error);
`endif
endinterface

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: radix-2 signed shift-add multiplier and restoring divider
// sharing a single WIDTH+1 bit adder (plus carry). One bit per step; the
// final step applies the sign correction so o_hi/o_lo are the finished
// result while i_last is high. o_hi/o_lo always show the value the working
// registers take at the current step.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    input  logic             i_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int AW = WIDTH + 2;

    // Working registers: MUL keeps partial product in hi and the multiplier
    // shifting out of lo; DIV keeps the partial remainder in hi and the
    // dividend shifting out of / quotient shifting into lo.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [AW-1:0]    w_x;
    logic [AW-1:0]    w_y;
    logic             w_sub;
    logic [AW-1:0]    w_sum;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Divider runs on magnitudes; the most-negative value maps to 2^(WIDTH-1)
    // which still fits as an unsigned WIDTH-bit magnitude.
    assign w_a_mag = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_b_mag = i_b[WIDTH-1] ? -i_b : i_b;

    // Select operands for the shared adder.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_x   = '0;
        w_y   = '0;
        w_sub = 1'b0;
        if (r_is_div) begin
            w_x   = {1'b0, r_hi, r_lo[WIDTH-1]};
            w_y   = {2'b00, r_m};
            w_sub = 1'b1;
        end else begin
            // Multiplier bit WIDTH-1 carries negative weight, so the last
            // partial product is subtracted: this is the signed fix-up.
            w_x   = {{2{r_hi[WIDTH-1]}}, r_hi};
            w_y   = r_lo[0] ? {{2{r_m[WIDTH-1]}}, r_m} : '0;
            w_sub = i_last;
        end
    end

    assign w_sum    = w_x + (w_sub ? ~w_y : w_y) + AW'(w_sub);
    assign w_div_ok = ~w_sum[AW-1];

    // Next working-register values for one iteration.
    always_comb begin
        w_hi_nxt = '0;
        w_lo_nxt = '0;
        if (r_is_div) begin
            w_hi_nxt = w_div_ok ? w_sum[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ok};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Quotient takes the XOR of operand signs, remainder the dividend's sign.
    assign o_hi = (i_last && r_is_div && r_neg_r) ? -w_hi_nxt : w_hi_nxt;
    assign o_lo = (i_last && r_is_div && r_neg_q) ? -w_lo_nxt : w_lo_nxt;

    // Load operands on an accepted start, then advance one bit per step.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? w_a_mag : i_b;
            r_m      <= i_is_div ? w_b_mag : i_a;
            r_is_div <= i_is_div;
            r_neg_q  <= i_is_div & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_is_div & i_a[WIDTH-1];
        end else if (i_step) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Latches operands on start (busy=0), returns a
// 2*WIDTH {HI,LO} result with a one-cycle done pulse. Logic/add/shift ops
// finish in one cycle; signed MUL/DIV iterate for WIDTH cycles in
// seq_muldiv_core. Define SEQ_ALU_FLAGS_EN to add registered Z/N/V flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clock,
    input  logic     clear,
    seq_alu_if.slave bus
);
    state_t             r_state;
    logic [SHW-1:0]     r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_sc_hi;
    logic [WIDTH-1:0]   w_sc_lo;
    logic               w_sc_err;

    // busy is low only in IDLE, so a start is accepted only there.
    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_div_zero = (bus.opcode == OP_DIV) && (bus.b == '0);
    assign w_load     = w_accept && is_iterative(bus.opcode) && !w_div_zero;
    assign w_step     = (r_state == ST_ITER);
    assign w_last     = w_step && (r_cnt == SHW'(WIDTH - 1));

    seq_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clock  (clock),
        .i_clear  (clear),
        .i_load   (w_load),
        .i_is_div (bus.opcode == OP_DIV),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_step   (w_step),
        .i_last   (w_last),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    assign w_sh   = bus.b[SHW-1:0];
    assign w_add  = bus.a + bus.b;
    assign w_diff = bus.a - bus.b;

    // Single-cycle results, plus the divide-by-zero and illegal-opcode outcomes.
    always_comb begin
        w_sc_hi  = '0;
        w_sc_lo  = '0;
        w_sc_err = 1'b0;
        case (bus.opcode)
            OP_AND:  w_sc_lo = bus.a & bus.b;
            OP_OR:   w_sc_lo = bus.a | bus.b;
            OP_NOT:  w_sc_lo = ~bus.a;
            OP_NEG:  w_sc_lo = -bus.a;
            OP_ADD:  w_sc_lo = w_add;
            OP_SUB:  w_sc_lo = w_diff;
            OP_MUL:  w_sc_lo = '0;
            OP_DIV: begin
                // Only reaches here with b == 0: result is {a, all-ones}.
                w_sc_hi  = bus.a;
                w_sc_lo  = '1;
                w_sc_err = 1'b1;
            end
            OP_SHR:  w_sc_lo = bus.a >> w_sh;
            OP_SHRA: w_sc_lo = $signed(bus.a) >>> w_sh;
            OP_SHL:  w_sc_lo = bus.a << w_sh;
            // Shifting by WIDTH yields zero, so amount 0 returns a unchanged.
            OP_ROR:  w_sc_lo = (bus.a >> w_sh) | (bus.a << (WIDTH - int'(w_sh)));
            OP_ROL:  w_sc_lo = (bus.a << w_sh) | (bus.a >> (WIDTH - int'(w_sh)));
            default: w_sc_err = 1'b1;
        endcase
    end

    // Control FSM with registered busy/done/error/result.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (w_load) begin
                            r_state <= ST_ITER;
                            r_cnt   <= '0;
                        end else begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_error  <= w_sc_err;
                            r_result <= {w_sc_hi, w_sc_lo};
                        end
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= {w_core_hi, w_core_lo};
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.error  = r_error;
    assign bus.result = r_result;

`ifdef SEQ_ALU_FLAGS_EN
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_v;
    logic             w_finish;
    logic [WIDTH-1:0] w_fin_lo;
    logic             w_sc_v;

    assign w_finish = (w_accept && !w_load) || w_last;
    assign w_fin_lo = w_last ? w_core_lo : w_sc_lo;

    // Signed overflow of the single-cycle arithmetic ops.
    always_comb begin
        w_sc_v = 1'b0;
        case (bus.opcode)
            OP_ADD:  w_sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
            OP_SUB:  w_sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            OP_NEG:  w_sc_v = bus.a[WIDTH-1] && (bus.a[WIDTH-2:0] == '0);
            default: w_sc_v = 1'b0;
        endcase
    end

    // Flags update with every done and hold until the next one.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (w_finish) begin
            r_flag_z <= (w_fin_lo == '0);
            r_flag_n <= w_fin_lo[WIDTH-1];
            r_flag_v <= w_last ? 1'b0 : w_sc_v;
        end
    end

    assign bus.flag_z = r_flag_z;
    assign bus.flag_n = r_flag_n;
    assign bus.flag_v = r_flag_v;
`endif

endmodule
